// File: rtl/cmp_nic.sv
// Network interface between the cmp CPU memory-mapped port and the ring router.
// Holds one packet per direction; outbound packets leave only on their VC phase.
module cmp_nic #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  localparam logic [0:1] ADDR_IN_BUF  = 2'b00;
  localparam logic [0:1] ADDR_IN_STS  = 2'b01;
  localparam logic [0:1] ADDR_OUT_BUF = 2'b10;
  localparam logic [0:1] ADDR_OUT_STS = 2'b11;

  logic [0:DATA_W-1] in_buf_q, in_buf_d;
  logic              in_full_q, in_full_d;
  logic [0:DATA_W-1] out_buf_q, out_buf_d;
  logic              out_full_q, out_full_d;
  logic              net_so_q, net_so_d;
  logic [0:DATA_W-1] net_do_q, net_do_d;

  logic cpu_rd, cpu_wr, rd_in_buf, wr_out_buf, rx_load, tx_fire;

  always_comb begin
    cpu_rd     = nicEn && !nicWrEn;
    cpu_wr     = nicEn && nicWrEn;
    rd_in_buf  = cpu_rd && (addr == ADDR_IN_BUF);
    // A write while a packet is still pending is silently dropped.
    wr_out_buf = cpu_wr && (addr == ADDR_OUT_BUF) && !out_full_q;
    rx_load    = net_si && !in_full_q;
    // out_buf[0] is the packet VC bit; it must match the router phase.
    tx_fire    = out_full_q && net_ro && (out_buf_q[0] == net_polarity);
  end

  always_comb begin
    d_out = '0;
    if (cpu_rd) begin
      case (addr)
        ADDR_IN_BUF:  d_out = in_buf_q;
        ADDR_IN_STS:  d_out[DATA_W-1] = in_full_q;
        ADDR_OUT_STS: d_out[DATA_W-1] = out_full_q;
        default:      d_out = '0;
      endcase
    end
  end

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    net_so_d   = tx_fire;
    net_do_d   = net_do_q;

    // Clear from a read is applied first so a simultaneous load still sets.
    if (rd_in_buf) in_full_d = 1'b0;
    if (rx_load) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    if (tx_fire) begin
      net_do_d   = out_buf_q;
      out_full_d = 1'b0;
    end
    if (wr_out_buf) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      net_so_q   <= 1'b0;
      net_do_q   <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      net_so_q   <= net_so_d;
      net_do_q   <= net_do_d;
    end
  end

  assign net_so = net_so_q;
  assign net_do = net_do_q;
  assign net_ri = ~in_full_q;

endmodule

// File: tb/tb_cmp_nic.sv
// Self-checking bench for cmp_nic: directed scenarios plus random traffic
// compared every cycle against a one-packet-per-direction mailbox model.
module tb_cmp_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn, nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;

  int n_assert = 0;
  int n_fail   = 0;

  // Mailbox model state
  logic [63:0] m_in_pkt, m_out_pkt, m_sent;
  bit          m_in_valid, m_out_valid, m_strobe;

  cmp_nic #(.DATA_W(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read();
    if (!nicEn || nicWrEn) return 64'd0;
    case (addr)
      2'b00:   return m_in_pkt;
      2'b01:   return {63'd0, m_in_valid};
      2'b11:   return {63'd0, m_out_valid};
      default: return 64'd0;
    endcase
  endfunction

  // Advance the mailbox model by one clock using the currently driven inputs.
  task automatic model_edge();
    bit send, take, accept, drain;
    if (reset) begin
      m_in_pkt = 0; m_out_pkt = 0; m_sent = 0;
      m_in_valid = 0; m_out_valid = 0; m_strobe = 0;
      return;
    end
    send   = m_out_valid && net_ro && (m_out_pkt[63] == net_polarity);
    take   = nicEn && nicWrEn && addr == 2'b10 && !m_out_valid;
    accept = net_si && !m_in_valid;
    drain  = nicEn && !nicWrEn && addr == 2'b00;
    m_strobe = send;
    if (send) begin m_sent = m_out_pkt; m_out_valid = 0; end
    if (take) begin m_out_pkt = d_in; m_out_valid = 1; end
    if (accept) begin
      m_in_pkt = net_di; m_in_valid = 1;
    end else if (drain) begin
      m_in_valid = 0;
    end
  endtask

  // One clock: compare all outputs to the model, take the edge, toggle phase.
  task automatic step();
    #1;
    chk("d_out",  d_out,  model_read());
    chk("net_ri", {63'd0, net_ri}, {63'd0, !m_in_valid});
    chk("net_so", {63'd0, net_so}, {63'd0, m_strobe});
    chk("net_do", net_do, m_sent);
    @(posedge clk);
    model_edge();
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr = 2'b00; net_si = 0;
  endtask

  task automatic cpu_read(input logic [0:1] a);
    nicEn = 1; nicWrEn = 0; addr = a;
  endtask

  task automatic cpu_write(input logic [0:1] a, input logic [63:0] v);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
  endtask

  initial begin
    int pulses;
    logic [63:0] seen;

    reset = 1; net_polarity = 0; net_ro = 0; net_di = 0; d_in = 0;
    idle();
    m_in_pkt = 'x; m_out_pkt = 'x; m_sent = 'x;
    @(posedge clk); model_edge(); #1;
    step();
    reset = 0;

    // Reset state
    cpu_read(2'b01); #1;
    chk("rst_in_sts", d_out, 64'd0);
    cpu_read(2'b11); #1;
    chk("rst_out_sts", d_out, 64'd0);
    chk("rst_ri", {63'd0, net_ri}, 64'd1);
    chk("rst_so", {63'd0, net_so}, 64'd0);
    chk("rst_do", net_do, 64'd0);
    step();

    // Single VC=1 packet
    net_ro = 1;
    cpu_write(2'b10, 64'h8000_0000_0000_00AA);
    step();
    cpu_read(2'b11); #1;
    chk("tx_pending", d_out, 64'd1);
    pulses = 0; seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (net_so) begin pulses++; seen = net_do; end
    end
    chk("tx_pulses", 64'(pulses), 64'd1);
    chk("tx_data", seen, 64'h8000_0000_0000_00AA);
    #1;
    chk("tx_done_sts", d_out, 64'd0);

    // Blocked router; second write dropped
    net_ro = 0;
    cpu_write(2'b10, 64'h0000_0000_0000_0011);
    step();
    idle();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (net_so) pulses++;
    end
    cpu_write(2'b10, 64'h0000_0000_0000_0022);
    step();
    idle();
    chk("blocked_pulses", 64'(pulses), 64'd0);
    net_ro = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (net_so) begin pulses++; seen = net_do; end
    end
    chk("unblock_pulses", 64'(pulses), 64'd1);
    chk("unblock_data", seen, 64'h0000_0000_0000_0011);

    // Receive path
    net_si = 1; net_di = 64'h0123_4567_89AB_CDEF;
    step();
    net_si = 0; #1;
    chk("rx_ri_low", {63'd0, net_ri}, 64'd0);
    cpu_read(2'b01); #1;
    chk("rx_in_sts", d_out, 64'd1);
    step();
    idle();
    net_si = 1; net_di = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    net_si = 0;
    cpu_read(2'b00); #1;
    chk("rx_data", d_out, 64'h0123_4567_89AB_CDEF);
    step();
    idle(); #1;
    chk("rx_ri_back", {63'd0, net_ri}, 64'd1);

    // Read of 00 coincident with load: load wins
    cpu_read(2'b00); net_si = 1; net_di = 64'h5;
    step();
    net_si = 0;
    cpu_read(2'b01); #1;
    chk("coinc_full", d_out, 64'd1);
    cpu_read(2'b00); #1;
    chk("coinc_data", d_out, 64'h5);
    idle();
    step();

    // Reset with both buffers full
    net_ro = 0;
    cpu_write(2'b10, 64'h8000_0000_0000_0077);
    step();
    idle();
    reset = 1;
    step();
    reset = 0;
    cpu_read(2'b01); #1;
    chk("rst2_in_sts", d_out, 64'd0);
    cpu_read(2'b11); #1;
    chk("rst2_out_sts", d_out, 64'd0);
    chk("rst2_ri", {63'd0, net_ri}, 64'd1);
    net_ro = 1;
    idle();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (net_so) pulses++;
    end
    chk("rst2_no_tx", 64'(pulses), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      nicEn   = $urandom_range(0, 1);
      nicWrEn = $urandom_range(0, 1);
      addr    = 2'($urandom_range(0, 3));
      d_in    = {$urandom(), $urandom()};
      net_ro  = ($urandom_range(0, 3) != 0);
      net_si  = ($urandom_range(0, 2) == 0);
      net_di  = {$urandom(), $urandom()};
      step();
    end
    reset = 0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_nic.md
# cmp_nic

Network interface that sits between the `cmp` processor's memory-mapped I/O port and its ring router on each NOC-Ring node. It buffers one 64-bit packet in each direction and exposes them to the CPU through four word addresses. It injects outbound packets into the router only on the matching virtual-channel polarity phase and accepts inbound packets whenever its input buffer is empty.

## Interface
Parameters
- `DATA_W`, 64: packet and CPU data width; bits are numbered `[0:DATA_W-1]`, with bit 0 as MSB.

Ports
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`.
- `addr`  in  [0:1]  register select: 00 input buffer (RO), 01 input status (RO), 10 output buffer (WO), 11 output status (RO).
- `d_in`  in  [0:63]  CPU write data.
- `d_out`  out  [0:63]  CPU read data, combinational.
- `nicEn`  in  1  access enable.
- `nicWrEn`  in  1  1 = write, 0 = read; qualified by `nicEn`.
- `net_so`  out  1  send strobe to router, registered, one-cycle pulse.
- `net_ro`  in  1  router ready to accept a packet.
- `net_do`  out  [0:63]  packet to router, registered.
- `net_polarity`  in  1  router phase; toggles each cycle.
- `net_si`  in  1  router delivers a packet this cycle.
- `net_ri`  out  1  NIC ready to receive; equals `~in_full`.
- `net_di`  in  [0:63]  packet from router.

## Operation
- State: `in_buf[0:63]`, `in_full`, `out_buf[0:63]`, `out_full`, `net_so`, `net_do`.
- Reset: `in_full=0`, `out_full=0`, `in_buf=0`, `out_buf=0`, `net_so=0`, `net_do=0`. This gives `net_ri=1`. Reset asserted mid-transfer discards both buffered packets. No packet is emitted in the reset cycle.
- CPU read (`nicEn=1`, `nicWrEn=0`): `d_out` is `in_buf` for addr 00, `{63'b0,in_full}` for 01, and `{63'b0,out_full}` for 11. Addr 10 reads 0. When `nicEn=0` or `nicWrEn=1`, `d_out=0`.
- Read of addr 00 clears `in_full` at the next edge, whether the buffer was full or empty. Other reads have no side effect.
- CPU write (`nicEn=1`, `nicWrEn=1`) to addr 10 with `out_full=0`: `out_buf<=d_in` and `out_full<=1`.
  - A write to addr 10 with `out_full=1` is dropped; the CPU must poll addr 11 first.
  - Writes to 00, 01, and 11 are ignored.
- Receive: `net_si=1` with `in_full=0` loads `in_buf<=net_di` and `in_full<=1`. `net_si` while `in_full=1` is ignored and the existing data is kept.
- Inject: at each edge, if `out_full && net_ro && (out_buf[0]==net_polarity)`, then `net_do<=out_buf`, `net_so<=1`, and `out_full<=0`. Otherwise `net_so<=0` and `net_do` holds its last value. `out_buf[0]` is the packet VC bit.

## Timing
- CPU read data is valid in the same cycle as `nicEn` (combinational, like `dmem` reads). Write effects and status changes are visible from the cycle after the edge.
- CPU write to `net_so`: at least 1 cycle. Worst case is 2 cycles if the polarity mismatches, assuming `net_ro=1`.
- Addr 00 read while `net_si=1` with `in_full=1`: the read clears `in_full`, and the incoming packet is ignored because it was offered while full. `net_ri` rises the cycle after the read.
- Addr 00 read while `net_si=1` with `in_full=0`: the load wins, giving `in_full=1` with the new data. The read returned stale data and clear does not override set.
- Inject and CPU write to 10 in the same cycle: the write is dropped because `out_full` was 1 at the edge. At most one packet is injected per cycle.
- `net_so` never stays high for two consecutive cycles, since `out_full` clears when it fires.

## Test plan
- Reset, then read 01 and 11 -> both `d_out=0`; `net_ri=1`, `net_so=0`, `net_do=0`.
- With `net_ro=1`, write `64'h8000_0000_0000_00AA` to 10 (VC=1) -> exactly one `net_so` pulse with `net_do=64'h8000_0000_0000_00AA` on the first edge where `net_polarity=1`. Addr 11 reads 1 before the pulse and 0 after.
- Hold `net_ro=0` for 5 cycles after a write to 10, then write a second word -> no `net_so`, and the second word is dropped. Raise `net_ro` -> only the first word is sent.
- Pulse `net_si` with `64'h0123_4567_89AB_CDEF` -> `net_ri` falls next cycle and addr 01 reads 1. A second `net_si` with `64'hFFFF...` is ignored. Addr 00 reads `64'h0123_4567_89AB_CDEF`, after which `in_full=0` and `net_ri=1`.
- Addr 00 read coincident with `net_si`, `in_full=0`, `net_di=64'h5` -> `in_full=1` and `in_buf=64'h5` after the edge.
- Assert `reset` for 1 cycle with both buffers full -> both status reads 0, `net_so` stays 0, and `net_ri=1`.
